branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the ID-stage branch comparator. It resolves MIPS conditional branches and links at configurable data width, and registers the outcome one cycle later. It also keeps a direct-mapped branch history table (BHT) of 2-bit saturating counters that the IF stage reads for prediction, plus branch and misprediction statistic counters. It sits between the ID-stage operand forwarding muxes and the PC-select / flush logic.

Parameters:
WIDTH, 32, operand width of a and b (>= 2)
PC_WIDTH, 32, width of PC inputs
BHT_DEPTH, 16, number of BHT entries; power of two, >= 2; IDX = log2(BHT_DEPTH)
CNT_WIDTH, 16, width of statistic counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
lookup_pc  input  PC_WIDTH  IF-stage PC for prediction
pred_taken  output  1  combinational; bit 1 of BHT[lookup_pc[IDX+1:2]]
in_valid  input  1  resolve request this cycle
op  input  4  branch operation code
a  input  WIDTH  rs operand (forwarded)
b  input  WIDTH  rt operand (forwarded)
pc  input  PC_WIDTH  PC of the branch being resolved
in_pred  input  1  prediction originally used for this branch
flush  input  1  kill the request presented this cycle
res_valid  output  1  registered: result valid
res_taken  output  1  registered: branch taken
res_link  output  1  registered: op writes $ra
res_mispredict  output  1  registered: in_pred != taken
branch_count  output  CNT_WIDTH  resolved conditional branches
mispredict_count  output  CNT_WIDTH  mispredicted branches

Behaviour:
- Op codes; signed tests use a[WIDTH-1]:
  - 0000: none, never taken
  - 0001: bne (a != b)
  - 0010: blez (a[MSB] | a==0)
  - 0011: bgtz (!a[MSB] & a!=0)
  - 0100: bltz (a[MSB])
  - 0101: bgez (!a[MSB])
  - 0111: beq (a == b)
  - 1000: j (always taken, unconditional)
  - 1100: bltzal
  - 1101: bgezal
  - all other codes: never taken, treated as none
- Conditional set: 0001, 0010, 0011, 0100, 0101, 0111, 1100, 1101.
- Accept condition: acc = in_valid & ~flush & ~reset.
- Latency 1: on the edge where acc is true, register the following:
  - res_valid = 1
  - res_taken = computed result
  - res_link = (op == 1100 | op == 1101), independent of taken
  - res_mispredict = (conditional | j) & (in_pred != taken)
- With acc false, the next edge sets res_valid = 0 and the other res_* outputs = 0. There is no hold/stall; the producer re-presents the request.
- BHT update, on acc & conditional only:
  - index i = pc[IDX+1:2]
  - taken: BHT[i] = min(BHT[i]+1, 3); not taken: max(BHT[i]-1, 0)
  - saturates at 11 and 00, no wrap
- j, none and undefined codes never touch the BHT.
- Same-cycle lookup and update of one index: pred_taken shows the pre-update value; the new value is visible from the next cycle.
- branch_count increments on acc & conditional.
- mispredict_count increments on acc & res_mispredict condition; this includes j with in_pred = 0.
- Both counters wrap modulo 2^CNT_WIDTH.
- flush drops the request this cycle entirely: no result, no BHT update, no count. It does not clear a result already registered, which is visible for its one cycle.
- Reset values:
  - res_valid = res_taken = res_link = res_mispredict = 0
  - counters = 0
  - every BHT entry = 01 (weakly not-taken), so pred_taken = 0
- reset dominates in_valid and flush.
- Reset mid-stream discards the pending request. Reset also clears an outstanding result: the cycle after a reset edge has res_valid = 0.

Test Plan:
- Reset, then lookup_pc = 0x0000_3000 -> pred_taken = 0; counters = 0; res_valid = 0.
- Sweep all 16 op codes with a = 0xFFFF_FFFF, b = 0xFFFF_FFFF; then a = 0, b = 5; then a = 7, b = 7; all with in_pred = 0 -> res_taken matches the table one cycle later. Expected for 0xFFFF_FFFF: beq = 1, bltz = 1, blez = 1, bgtz = 0, bgez = 0, bltzal = 1 with res_link = 1, undefined codes = 0.
- pc = 0x0000_3004, beq taken three times back to back -> BHT[1] goes 01→10→11→11; pred_taken for lookup_pc = 0x0000_3004 reads 1 after the first update edge; branch_count = 3.
- Same cycle: in_valid beq taken on pc 0x3008, lookup_pc = 0x3008 -> pred_taken = 0 that cycle, 1 the next cycle.
- in_pred = 1, bne with a = b = 4 -> res_mispredict = 1, mispredict_count += 1. Repeat with flush = 1 -> res_valid = 0 next cycle, counts and BHT unchanged.
- Counter wrap: CNT_WIDTH = 4, issue 17 conditional branches -> branch_count = 1. Assert reset during an in_valid cycle -> next cycle res_valid = 0 and all BHT entries = 01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolves MIPS conditional branches and links, and registers the outcome one cycle later.
// Keeps a direct-mapped BHT of 2-bit saturating counters and branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int PC_WIDTH  = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_taken,
  input  logic                 in_valid,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 in_pred,
  input  logic                 flush,
  output logic                 res_valid,
  output logic                 res_taken,
  output logic                 res_link,
  output logic                 res_mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX = $clog2(BHT_DEPTH);

  typedef enum logic [3:0] {
    OP_NONE   = 4'b0000,
    OP_BNE    = 4'b0001,
    OP_BLEZ   = 4'b0010,
    OP_BGTZ   = 4'b0011,
    OP_BLTZ   = 4'b0100,
    OP_BGEZ   = 4'b0101,
    OP_BEQ    = 4'b0111,
    OP_J      = 4'b1000,
    OP_BLTZAL = 4'b1100,
    OP_BGEZAL = 4'b1101
  } op_e;

  logic [1:0]     bht [BHT_DEPTH];
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] lk_idx;
  logic           a_neg;
  logic           a_zero;
  logic           a_eq_b;
  logic           taken;
  logic           cond;
  logic           is_j;
  logic           link;
  logic           mispredict;
  logic           acc;
  logic           unused_pc_bits;

  assign upd_idx = pc[IDX+1:2];
  assign lk_idx  = lookup_pc[IDX+1:2];
  assign unused_pc_bits = ^{pc[PC_WIDTH-1:IDX+2], pc[1:0],
                            lookup_pc[PC_WIDTH-1:IDX+2], lookup_pc[1:0]};

  // Read port sees the pre-update value when lookup and update hit the same entry.
  assign pred_taken = bht[lk_idx][1];

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);
  assign a_eq_b = (a == b);

  always_comb begin
    taken = 1'b0;
    cond  = 1'b0;
    is_j  = 1'b0;
    case (op)
      OP_BNE:    begin cond = 1'b1; taken = ~a_eq_b;           end
      OP_BLEZ:   begin cond = 1'b1; taken = a_neg | a_zero;    end
      OP_BGTZ:   begin cond = 1'b1; taken = ~a_neg & ~a_zero;  end
      OP_BLTZ:   begin cond = 1'b1; taken = a_neg;             end
      OP_BGEZ:   begin cond = 1'b1; taken = ~a_neg;            end
      OP_BEQ:    begin cond = 1'b1; taken = a_eq_b;            end
      OP_J:      begin is_j = 1'b1; taken = 1'b1;              end
      OP_BLTZAL: begin cond = 1'b1; taken = a_neg;             end
      OP_BGEZAL: begin cond = 1'b1; taken = ~a_neg;            end
      default:   begin taken = 1'b0;                           end
    endcase
  end

  assign link       = (op == OP_BLTZAL) | (op == OP_BGEZAL);
  assign mispredict = (cond | is_j) & (in_pred != taken);
  assign acc        = in_valid & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid        <= 1'b0;
      res_taken        <= 1'b0;
      res_link         <= 1'b0;
      res_mispredict   <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else begin
      res_valid      <= acc;
      res_taken      <= acc & taken;
      res_link       <= acc & link;
      res_mispredict <= acc & mispredict;
      if (acc && cond) begin
        branch_count <= branch_count + CNT_WIDTH'(1);
        if (taken && bht[upd_idx] != 2'b11) begin
          bht[upd_idx] <= bht[upd_idx] + 2'd1;
        end else if (!taken && bht[upd_idx] != 2'b00) begin
          bht[upd_idx] <= bht[upd_idx] - 2'd1;
        end
      end
      if (acc && mispredict) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a behavioural model
// (signed-arithmetic branch rules, integer BHT counters, modulo statistics).
module tb_branch_resolve_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   lookup_pc;
  logic          pred_taken;
  logic          in_valid;
  logic [3:0]    op;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [31:0]   pc;
  logic          in_pred;
  logic          flush;
  logic          res_valid;
  logic          res_taken;
  logic          res_link;
  logic          res_mispredict;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  int m_bht [16];
  int m_bcnt;
  int m_mcnt;
  logic [15:0] ones_exp;

  branch_resolve_unit #(
    .WIDTH(32),
    .PC_WIDTH(32),
    .BHT_DEPTH(16),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lookup_pc(lookup_pc),
    .pred_taken(pred_taken),
    .in_valid(in_valid),
    .op(op),
    .a(a),
    .b(b),
    .pc(pc),
    .in_pred(in_pred),
    .flush(flush),
    .res_valid(res_valid),
    .res_taken(res_taken),
    .res_link(res_link),
    .res_mispredict(res_mispredict),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx;
    sx = signed'(x);
    case (o)
      4'd1:    return x != y;
      4'd2:    return sx <= 0;
      4'd3:    return sx > 0;
      4'd4:    return sx < 0;
      4'd5:    return sx >= 0;
      4'd7:    return x == y;
      4'd8:    return 1'b1;
      4'd12:   return sx < 0;
      4'd13:   return sx >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_cond(input logic [3:0] o);
    return o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd12, 4'd13};
  endfunction

  function automatic int idx_of(input logic [31:0] p);
    return int'((p >> 2) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // One clock: drive, check prediction before the edge, then check registered results after it.
  task automatic step(input logic v, input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] pcv, input logic p, input logic f, input logic r,
                      input logic [31:0] lk);
    bit t, lnk, mis, acc;
    bit e_v, e_t, e_l, e_m;
    in_valid = v; op = o; a = aa; b = bb; pc = pcv; in_pred = p; flush = f; reset = r; lookup_pc = lk;
    #1;
    chk("pred_pre", {31'd0, pred_taken}, {31'd0, m_bht[idx_of(lk)] >= 2});
    acc = v && !f && !r;
    t   = ref_taken(o, aa, bb);
    lnk = (o == 4'd12) || (o == 4'd13);
    mis = (is_cond(o) || o == 4'd8) && (p != t);
    e_v = 0; e_t = 0; e_l = 0; e_m = 0;
    if (r) begin
      model_reset();
    end else if (acc) begin
      e_v = 1; e_t = t; e_l = lnk; e_m = mis;
      if (is_cond(o)) begin
        m_bcnt = (m_bcnt + 1) % (1 << CW);
        if (t) m_bht[idx_of(pcv)] = (m_bht[idx_of(pcv)] == 3) ? 3 : m_bht[idx_of(pcv)] + 1;
        else   m_bht[idx_of(pcv)] = (m_bht[idx_of(pcv)] == 0) ? 0 : m_bht[idx_of(pcv)] - 1;
      end
      if (mis) m_mcnt = (m_mcnt + 1) % (1 << CW);
    end
    @(posedge clk);
    #1;
    chk("res_valid",      {31'd0, res_valid},      {31'd0, e_v});
    chk("res_taken",      {31'd0, res_taken},      {31'd0, e_t});
    chk("res_link",       {31'd0, res_link},       {31'd0, e_l});
    chk("res_mispredict", {31'd0, res_mispredict}, {31'd0, e_m});
    chk("branch_count",     {{(32-CW){1'b0}}, branch_count},     m_bcnt);
    chk("mispredict_count", {{(32-CW){1'b0}}, mispredict_count}, m_mcnt);
    chk("pred_post", {31'd0, pred_taken}, {31'd0, m_bht[idx_of(lk)] >= 2});
  endtask

  task automatic idle(input logic [31:0] lk);
    step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, lk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; pc = '0;
    in_pred = 1'b0; flush = 1'b0; lookup_pc = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state
    step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h3000);
    chk("rst_pred",   {31'd0, pred_taken}, 32'd0);
    chk("rst_bcount", {{(32-CW){1'b0}}, branch_count}, 32'd0);

    // Op sweep, three operand patterns; all-ones pattern also against a fixed table
    ones_exp = 16'h1194;
    for (int o = 0; o < 16; o++) begin
      step(1'b1, 4'(o), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h2000);
      chk("ones_table", {31'd0, res_taken}, {31'd0, ones_exp[o]});
    end
    for (int o = 0; o < 16; o++)
      step(1'b1, 4'(o), 32'd0, 32'd5, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h2000);
    for (int o = 0; o < 16; o++)
      step(1'b1, 4'(o), 32'd7, 32'd7, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h2000);

    // BHT saturation on index 1
    step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h3004);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd7, 32'd9, 32'd9, 32'h3004, 1'b0, 1'b0, 1'b0, 32'h3004);
      chk("bht1_pred", {31'd0, pred_taken}, 32'd1);
    end
    chk("bcount3", {{(32-CW){1'b0}}, branch_count}, 32'd3);

    // Same-cycle lookup/update on index 2
    step(1'b1, 4'd7, 32'd1, 32'd1, 32'h3008, 1'b0, 1'b0, 1'b0, 32'h3008);
    chk("same_cycle_next", {31'd0, pred_taken}, 32'd1);

    // Mispredict, then the same request flushed
    step(1'b1, 4'd1, 32'd4, 32'd4, 32'h300C, 1'b1, 1'b0, 1'b0, 32'h300C);
    chk("mispred", {31'd0, res_mispredict}, 32'd1);
    step(1'b1, 4'd1, 32'd4, 32'd4, 32'h300C, 1'b1, 1'b1, 1'b0, 32'h300C);
    chk("flush_valid", {31'd0, res_valid}, 32'd0);
    // j with in_pred = 0 counts as a mispredict but not as a branch
    step(1'b1, 4'd8, 32'd0, 32'd0, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h3010);

    // Counter wrap at CNT_WIDTH = 4
    step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 17; k++)
      step(1'b1, 4'd5, 32'd3, 32'd0, 32'(k * 4), 1'b0, 1'b0, 1'b0, 32'd0);
    chk("bcount_wrap", {{(32-CW){1'b0}}, branch_count}, 32'd1);

    // Reset during a valid request, then every entry reads weakly not-taken
    step(1'b1, 4'd7, 32'd2, 32'd2, 32'h0004, 1'b0, 1'b0, 1'b0, 32'h0004);
    step(1'b1, 4'd7, 32'd2, 32'd2, 32'h0004, 1'b0, 1'b0, 1'b1, 32'h0004);
    chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
    for (int i = 0; i < 16; i++) idle(32'(i * 4));
    step(1'b1, 4'd4, 32'h8000_0000, 32'd0, 32'h0014, 1'b0, 1'b0, 1'b0, 32'h0014);
    chk("weak_nt_to_wt", {31'd0, pred_taken}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra, rb, sel;
      sel = $urandom;
      case (sel[1:0])
        2'd0: ra = 32'd0;
        2'd1: ra = 32'hFFFF_FFFF;
        2'd2: ra = 32'h8000_0000 | $urandom_range(0, 3);
        default: ra = $urandom;
      endcase
      rb = sel[2] ? ra : $urandom_range(0, 7);
      step(sel[3] | sel[4] | sel[5], 4'($urandom_range(0, 15)), ra, rb, $urandom,
           sel[6], (sel[9:7] == 3'd0), (sel[15:10] == 6'd0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
